// File: rtl/nibble_seq_ctrl_pkg.sv
// Shared types for the nibble sequencer: operation codes, ALU codes, FSM states
// and the mapping from sequencer op to ALU op.
package nibble_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        SEQ_ADD,
        SEQ_SUB,
        SEQ_CMP,
        SEQ_AND,
        SEQ_OR,
        SEQ_XOR
    } seq_op_t;

    typedef enum logic [2:0] {
        ALU_ADC,
        ALU_SBC,
        ALU_AND,
        ALU_OR,
        ALU_XOR
    } alu_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_A,
        ST_RD_B,
        ST_EXEC,
        ST_FIN
    } seq_state_t;

    // CMP is a subtract whose result is discarded
    function automatic alu_op_t seq_to_alu(input seq_op_t op);
        case (op)
            SEQ_ADD: return ALU_ADC;
            SEQ_SUB: return ALU_SBC;
            SEQ_CMP: return ALU_SBC;
            SEQ_AND: return ALU_AND;
            SEQ_OR:  return ALU_OR;
            SEQ_XOR: return ALU_XOR;
            default: return ALU_ADC;
        endcase
    endfunction

endpackage

// File: rtl/nibble_seq_ctrl_if.sv
// Command/status and nibble-RAM port bundle between the CPU core side (master)
// and the sequencer (slave).
interface nibble_seq_ctrl_if #(
    parameter int MAX_NIBBLES = 8,
    parameter int ADDR_WIDTH  = 12
);
    import nibble_seq_ctrl_pkg::*;

    localparam int LEN_W = $clog2(MAX_NIBBLES + 1);

    logic                  start;
    seq_op_t               op;
    logic [LEN_W-1:0]      len;
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic [ADDR_WIDTH-1:0] addr_dst;
    logic                  carry_in_en;
    logic                  flag_carry_in;
    logic                  flag_decimal_in;
    logic                  busy;
    logic                  done;
    logic                  flag_carry_out;
    logic                  flag_zero_out;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [3:0]            mem_read_data;
    logic                  mem_write_en;
    logic [3:0]            mem_write_data;

    modport master (
        output start, op, len, addr_a, addr_b, addr_dst,
               carry_in_en, flag_carry_in, flag_decimal_in, mem_read_data,
        input  busy, done, flag_carry_out, flag_zero_out,
               mem_addr, mem_write_en, mem_write_data
    );

    modport slave (
        input  start, op, len, addr_a, addr_b, addr_dst,
               carry_in_en, flag_carry_in, flag_decimal_in, mem_read_data,
        output busy, done, flag_carry_out, flag_zero_out,
               mem_addr, mem_write_en, mem_write_data
    );

endinterface

// File: rtl/nibble_seq_ctrl_alu.sv
// 4-bit ALU: binary/BCD add-with-carry, subtract-with-borrow, and bitwise ops.
// For subtract the carry is a borrow (1 = borrow in / borrow out).
module nibble_seq_ctrl_alu
    import nibble_seq_ctrl_pkg::*;
(
    input  alu_op_t    i_op,
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_carry,
    input  logic       i_decimal,
    output logic [3:0] o_result,
    output logic       o_carry,
    output logic       o_zero
);
    logic [4:0] w_sum;
    logic [4:0] w_diff;

    assign w_sum  = {1'b0, i_a} + {1'b0, i_b} + {4'b0, i_carry};
    assign w_diff = {1'b0, i_a} - {1'b0, i_b} - {4'b0, i_carry};

    always_comb begin
        o_result = 4'h0;
        o_carry  = i_carry;
        case (i_op)
            ALU_ADC: begin
                if (i_decimal && (w_sum > 5'd9)) begin
                    o_result = w_sum[3:0] + 4'd6;
                    o_carry  = 1'b1;
                end else begin
                    o_result = w_sum[3:0];
                    o_carry  = w_sum[4];
                end
            end
            ALU_SBC: begin
                // BCD borrow: wrap the digit back into 0..9
                o_result = (i_decimal && w_diff[4]) ? (w_diff[3:0] - 4'd6) : w_diff[3:0];
                o_carry  = w_diff[4];
            end
            ALU_AND: o_result = i_a & i_b;
            ALU_OR:  o_result = i_a | i_b;
            ALU_XOR: o_result = i_a ^ i_b;
            default: o_result = 4'h0;
        endcase
    end

    assign o_zero = (o_result == 4'h0);

endmodule

// File: rtl/nibble_seq_ctrl.sv
// Multi-nibble arithmetic sequencer: walks two RAM operands LS nibble first,
// three cycles per nibble (read A, read B, execute/write), chaining carry.
module nibble_seq_ctrl
    import nibble_seq_ctrl_pkg::*;
#(
    parameter int MAX_NIBBLES = 8,
    parameter int ADDR_WIDTH  = 12
) (
    input  logic             i_clk,
    input  logic             i_reset,
    nibble_seq_ctrl_if.slave bus
);
    localparam int LEN_W = $clog2(MAX_NIBBLES + 1);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_NIBBLES);

    seq_state_t            r_state;
    seq_op_t               r_op;
    logic [LEN_W-1:0]      r_len;
    logic [LEN_W-1:0]      r_idx;
    logic [ADDR_WIDTH-1:0] r_addr_a;
    logic [ADDR_WIDTH-1:0] r_addr_b;
    logic [ADDR_WIDTH-1:0] r_addr_dst;
    logic                  r_decimal;
    logic                  r_carry;
    logic                  r_zero_acc;
    logic [3:0]            r_temp_a;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_wr_en;
    logic                  r_carry_out;
    logic                  r_zero_out;
    logic [ADDR_WIDTH-1:0] r_mem_addr;

    logic [LEN_W-1:0]      w_len_clamped;
    logic [LEN_W-1:0]      w_idx_nxt;
    logic                  w_last;
    logic                  w_carry_start;
    logic [3:0]            w_alu_result;
    logic                  w_alu_carry;
    logic                  w_alu_zero;

    assign w_len_clamped = (bus.len > MAX_LEN) ? MAX_LEN : bus.len;
    assign w_idx_nxt     = r_idx + 1'b1;
    assign w_last        = !(w_idx_nxt < r_len);
    assign w_carry_start = bus.carry_in_en & bus.flag_carry_in;

    // Operand B is taken straight off the RAM read port in EXEC
    nibble_seq_ctrl_alu u_alu (
        .i_op      (seq_to_alu(r_op)),
        .i_a       (r_temp_a),
        .i_b       (bus.mem_read_data),
        .i_carry   (r_carry),
        .i_decimal (r_decimal),
        .o_result  (w_alu_result),
        .o_carry   (w_alu_carry),
        .o_zero    (w_alu_zero)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_op        <= SEQ_ADD;
            r_len       <= '0;
            r_idx       <= '0;
            r_addr_a    <= '0;
            r_addr_b    <= '0;
            r_addr_dst  <= '0;
            r_decimal   <= 1'b0;
            r_carry     <= 1'b0;
            r_zero_acc  <= 1'b1;
            r_temp_a    <= 4'h0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_wr_en     <= 1'b0;
            r_carry_out <= 1'b0;
            r_zero_out  <= 1'b1;
            r_mem_addr  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_op       <= bus.op;
                        r_len      <= w_len_clamped;
                        r_idx      <= '0;
                        r_addr_a   <= bus.addr_a;
                        r_addr_b   <= bus.addr_b;
                        r_addr_dst <= bus.addr_dst;
                        r_decimal  <= bus.flag_decimal_in & (bus.op != SEQ_CMP);
                        r_carry    <= w_carry_start;
                        r_zero_acc <= 1'b1;
                        r_busy     <= 1'b1;
                        if (w_len_clamped == '0) begin
                            r_state     <= ST_FIN;
                            r_done      <= 1'b1;
                            r_carry_out <= w_carry_start;
                            r_zero_out  <= 1'b1;
                        end else begin
                            r_state    <= ST_RD_A;
                            r_mem_addr <= bus.addr_a;
                        end
                    end
                end
                ST_RD_A: begin
                    r_state    <= ST_RD_B;
                    r_mem_addr <= r_addr_b + ADDR_WIDTH'(r_idx);
                end
                ST_RD_B: begin
                    r_temp_a   <= bus.mem_read_data;
                    r_state    <= ST_EXEC;
                    r_mem_addr <= r_addr_dst + ADDR_WIDTH'(r_idx);
                    r_wr_en    <= (r_op != SEQ_CMP);
                end
                ST_EXEC: begin
                    r_wr_en    <= 1'b0;
                    r_carry    <= w_alu_carry;
                    r_zero_acc <= r_zero_acc & w_alu_zero;
                    r_idx      <= w_idx_nxt;
                    // Flags land together with done so the core sees them on the pulse
                    if (w_last) begin
                        r_state     <= ST_FIN;
                        r_done      <= 1'b1;
                        r_carry_out <= w_alu_carry;
                        r_zero_out  <= r_zero_acc & w_alu_zero;
                    end else begin
                        r_state    <= ST_RD_A;
                        r_mem_addr <= r_addr_a + ADDR_WIDTH'(w_idx_nxt);
                    end
                end
                ST_FIN: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy           = r_busy;
    assign bus.done           = r_done;
    assign bus.flag_carry_out = r_carry_out;
    assign bus.flag_zero_out  = r_zero_out;
    assign bus.mem_addr       = r_mem_addr;
    // A reset landing on an EXEC cycle must suppress that cycle's write
    assign bus.mem_write_en   = r_wr_en & ~i_reset;
    assign bus.mem_write_data = w_alu_result;

endmodule

// File: tb/tb_nibble_seq_ctrl.sv
// Directed bench for nibble_seq_ctrl: vector table of operations against a
// RAM model, plus hand sequences for busy-start, wrap and reset abort.
module tb_nibble_seq_ctrl;
    import nibble_seq_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    nibble_seq_ctrl_if #(.MAX_NIBBLES(8), .ADDR_WIDTH(12)) bus ();

    nibble_seq_ctrl #(.MAX_NIBBLES(8), .ADDR_WIDTH(12)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    // Nibble RAM with registered read and a bench-side preload port
    logic [3:0]  ram [0:4095];
    logic        tb_we = 1'b0;
    logic [11:0] tb_waddr = '0;
    logic [3:0]  tb_wdata = '0;
    int          wr_cnt = 0;

    always @(posedge clk) begin
        if (tb_we) ram[tb_waddr] <= tb_wdata;
        else if (bus.mem_write_en) begin
            ram[bus.mem_addr] <= bus.mem_write_data;
            wr_cnt <= wr_cnt + 1;
        end
        bus.mem_read_data <= ram[bus.mem_addr];
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [11:0] a, input logic [3:0] d);
        tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
        tick();
        tb_we = 1'b0;
    endtask

    task automatic load(input logic [11:0] base, input logic [31:0] val, input int n);
        logic [11:0] a;
        for (int i = 0; i < n; i++) begin
            a = base + 12'(i);
            poke(a, val[4*i +: 4]);
        end
    endtask

    function automatic logic [31:0] peek(input logic [11:0] base, input int n);
        logic [31:0] r;
        logic [11:0] a;
        r = '0;
        for (int i = 0; i < n; i++) begin
            a = base + 12'(i);
            r[4*i +: 4] = ram[a];
        end
        return r;
    endfunction

    typedef struct {
        string       name;
        seq_op_t     op;
        logic [3:0]  len;
        logic [11:0] aa, ab, ad;
        logic [31:0] va, vb;
        logic        cie, cin, dec;
        logic [31:0] exp_d;
        logic        exp_c, exp_z;
    } vec_t;

    function automatic vec_t mk(input string name, input seq_op_t op, input int len,
                                input logic [11:0] aa, input logic [11:0] ab, input logic [11:0] ad,
                                input logic [31:0] va, input logic [31:0] vb,
                                input logic cie, input logic cin, input logic dec,
                                input logic [31:0] ed, input logic ec, input logic ez);
        vec_t v;
        v.name = name; v.op = op; v.len = 4'(len);
        v.aa = aa; v.ab = ab; v.ad = ad; v.va = va; v.vb = vb;
        v.cie = cie; v.cin = cin; v.dec = dec;
        v.exp_d = ed; v.exp_c = ec; v.exp_z = ez;
        return v;
    endfunction

    task automatic run(input vec_t v);
        int          n, cyc, w0;
        logic [31:0] mask;
        logic [11:0] a_nxt;
        n = (v.len > 4'd8) ? 8 : int'(v.len);
        mask = (n == 0) ? 32'h0 : (32'hFFFF_FFFF >> (32 - 4*n));
        a_nxt = v.aa + 12'd1;
        load(v.ad, 32'h3333_3333, n);
        load(v.aa, v.va, n);
        load(v.ab, v.vb, n);
        w0 = wr_cnt;
        bus.op = v.op; bus.len = v.len;
        bus.addr_a = v.aa; bus.addr_b = v.ab; bus.addr_dst = v.ad;
        bus.carry_in_en = v.cie; bus.flag_carry_in = v.cin; bus.flag_decimal_in = v.dec;
        bus.start = 1'b1;
        tick();
        // Scramble command inputs: they must only be sampled with start
        bus.start = 1'b0; bus.op = SEQ_XOR; bus.len = 4'd1;
        bus.addr_a = 12'h7E7; bus.addr_b = 12'h7E7; bus.addr_dst = 12'h7E7;
        bus.carry_in_en = ~v.cie; bus.flag_carry_in = ~v.cin; bus.flag_decimal_in = ~v.dec;
        cyc = 1;
        check({v.name, " busy@T+1"}, bus.busy, 1);
        while (!bus.done && cyc < 60) begin
            if (cyc == 1) check({v.name, " rdA0 addr"}, bus.mem_addr, v.aa);
            if (cyc == 2) check({v.name, " rdB0 addr"}, bus.mem_addr, v.ab);
            if (cyc == 3) begin
                check({v.name, " exec0 addr"}, bus.mem_addr, v.ad);
                check({v.name, " exec0 we"}, bus.mem_write_en, (v.op != SEQ_CMP));
            end
            if (cyc == 4 && n > 1) check({v.name, " rdA1 addr"}, bus.mem_addr, a_nxt);
            tick();
            cyc++;
        end
        check({v.name, " done latency"}, cyc, 3*n + 1);
        check({v.name, " carry"}, bus.flag_carry_out, v.exp_c);
        check({v.name, " zero"}, bus.flag_zero_out, v.exp_z);
        tick();
        check({v.name, " busy after"}, bus.busy, 0);
        check({v.name, " done pulse"}, bus.done, 0);
        if (n > 0) check({v.name, " dst"}, peek(v.ad, n), v.exp_d & mask);
        check({v.name, " writes"}, wr_cnt - w0, (v.op == SEQ_CMP) ? 0 : n);
    endtask

    vec_t vecs[$];

    initial begin
        int w0;
        vecs.push_back(mk("dadd4",  SEQ_ADD, 4, 12'h010, 12'h020, 12'h030, 32'h0399, 32'h0001, 0, 0, 1, 32'h0400, 0, 0));
        vecs.push_back(mk("bsub_a", SEQ_SUB, 2, 12'h040, 12'h050, 12'h060, 32'h10,   32'h01,   0, 0, 0, 32'h0F,   0, 0));
        vecs.push_back(mk("bsub_b", SEQ_SUB, 2, 12'h040, 12'h050, 12'h060, 32'h00,   32'h01,   0, 0, 0, 32'hFF,   1, 0));
        vecs.push_back(mk("cmp_eq", SEQ_CMP, 3, 12'h070, 12'h080, 12'h090, 32'h5A5,  32'h5A5,  0, 0, 1, 32'h333,  0, 1));
        vecs.push_back(mk("cmp_lt", SEQ_CMP, 2, 12'h070, 12'h080, 12'h090, 32'h12,   32'h34,   0, 0, 1, 32'h33,   1, 0));
        vecs.push_back(mk("wrap",   SEQ_ADD, 2, 12'hFFF, 12'h100, 12'h200, 32'h12,   32'h34,   1, 1, 0, 32'h47,   0, 0));
        vecs.push_back(mk("len0",   SEQ_ADD, 0, 12'h0A0, 12'h0B0, 12'h0C0, 32'h0,    32'h0,    1, 1, 0, 32'h0,    1, 1));
        vecs.push_back(mk("len15",  SEQ_ADD, 15, 12'h0D0, 12'h0E0, 12'h0F0, 32'hFFFF_FFFF, 32'h1, 0, 0, 0, 32'h0, 1, 1));
        vecs.push_back(mk("and",    SEQ_AND, 2, 12'h110, 12'h120, 12'h130, 32'h3C,   32'h0F,   1, 1, 1, 32'h0C,   1, 0));
        vecs.push_back(mk("xor",    SEQ_XOR, 2, 12'h110, 12'h120, 12'h130, 32'h5A,   32'h5A,   0, 0, 0, 32'h00,   0, 1));
        vecs.push_back(mk("or",     SEQ_OR,  2, 12'h110, 12'h120, 12'h130, 32'h50,   32'h0A,   1, 0, 0, 32'h5A,   0, 0));
        vecs.push_back(mk("dsub",   SEQ_SUB, 2, 12'h140, 12'h150, 12'h160, 32'h10,   32'h01,   0, 0, 1, 32'h09,   0, 0));
        vecs.push_back(mk("inplace", SEQ_SUB, 2, 12'h170, 12'h180, 12'h170, 32'h25,  32'h13,   0, 0, 0, 32'h12,   0, 0));
        vecs.push_back(mk("dadd_c", SEQ_ADD, 2, 12'h190, 12'h1A0, 12'h1B0, 32'h99,   32'h01,   0, 0, 1, 32'h00,   1, 1));
        vecs.push_back(mk("sub_cin", SEQ_SUB, 2, 12'h190, 12'h1A0, 12'h1B0, 32'h00,  32'h00,   1, 1, 0, 32'hFF,   1, 0));

        bus.start = 1'b0; bus.op = SEQ_ADD; bus.len = '0;
        bus.addr_a = '0; bus.addr_b = '0; bus.addr_dst = '0;
        bus.carry_in_en = 1'b0; bus.flag_carry_in = 1'b0; bus.flag_decimal_in = 1'b0;

        reset = 1'b1;
        tick(); tick(); tick();
        check("rst busy", bus.busy, 0);
        check("rst done", bus.done, 0);
        check("rst we", bus.mem_write_en, 0);
        check("rst carry", bus.flag_carry_out, 0);
        check("rst zero", bus.flag_zero_out, 1);
        check("rst addr", bus.mem_addr, 0);
        reset = 1'b0;
        tick();

        foreach (vecs[i]) run(vecs[i]);

        // Start while busy is ignored: single-nibble add, second start mid-op
        load(12'h300, 32'h3, 1); load(12'h310, 32'h4, 1);
        bus.op = SEQ_ADD; bus.len = 4'd1; bus.carry_in_en = 1'b0;
        bus.addr_a = 12'h300; bus.addr_b = 12'h310; bus.addr_dst = 12'h320;
        bus.start = 1'b1; tick(); bus.start = 1'b0;       // T+1
        tick();                                           // T+2
        bus.len = 4'd0; bus.start = 1'b1; tick(); bus.start = 1'b0;  // T+3
        tick();                                           // T+4
        check("busystart done@T+4", bus.done, 1);
        tick();
        check("busystart no 2nd done a", bus.done, 0);
        tick();
        check("busystart no 2nd done b", bus.done, 0);
        check("busystart idle", bus.busy, 0);
        check("busystart dst", ram[12'h320], 4'h7);

        // Reset during EXEC of nibble 1 aborts with no write that cycle
        load(12'h420, 32'hCCCC, 4); load(12'h400, 32'h1111, 4); load(12'h410, 32'h2222, 4);
        w0 = wr_cnt;
        bus.op = SEQ_ADD; bus.len = 4'd4; bus.carry_in_en = 1'b0; bus.flag_decimal_in = 1'b0;
        bus.addr_a = 12'h400; bus.addr_b = 12'h410; bus.addr_dst = 12'h420;
        bus.start = 1'b1; tick(); bus.start = 1'b0;       // T+1
        tick(); tick(); tick(); tick(); tick();           // T+6: EXEC nibble 1
        check("abort we before rst", bus.mem_write_en, 1);
        reset = 1'b1;
        #1;
        check("abort we gated", bus.mem_write_en, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort busy", bus.busy, 0);
        check("abort done", bus.done, 0);
        tick();
        check("abort no done", bus.done, 0);
        check("abort writes", wr_cnt - w0, 1);
        check("abort nib0", ram[12'h420], 4'h3);
        check("abort nib1", ram[12'h421], 4'hC);

        run(vecs[1]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
